// File: rtl/data_types_pkg.sv
// Shared UART types: receiver state encoding, parity-mode constants and a sampling helper.
package data_types_pkg;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop,
    RxWaitIdle
  } rx_state_t;

  localparam logic ParityEven = 1'b0;
  localparam logic ParityOdd  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one tick every baud_div+1 clocks, restartable via clear.
module uart_baud_gen (
  input  logic        uart_clk,
  input  logic        uart_rst_n,
  input  logic        clear,
  input  logic [15:0] baud_div,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;

  // >= keeps the period bounded if baud_div shrinks below the running count
  assign tick = (cnt_q >= baud_div);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronized input, oversampled majority-vote bit recovery and a
// single-entry holding register with ready/valid handshake and overrun reporting.
module uart_rx
  import data_types_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 uart_clk,
  input  logic                 uart_rst_n,
  input  logic                 rx,
  input  logic [15:0]          baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CntW-1:0] SampA   = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] SampB   = CntW'(OVERSAMPLE / 2);
  localparam logic [CntW-1:0] SampC   = CntW'(OVERSAMPLE / 2 + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

  // Input synchronizer; fill_q marks stages that hold real line samples, so the
  // reset value of 1 can never masquerade as a high-to-low edge after reset.
  logic [SYNC_STAGES-1:0] sync_q, sync_d, fill_q, fill_d;
  logic                   rx_sync, sync_full, line_high_q;

  if (SYNC_STAGES > 1) begin : g_sync_multi
    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    assign fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
  end else begin : g_sync_single
    assign sync_d = rx;
    assign fill_d = 1'b1;
  end

  assign rx_sync   = sync_q[SYNC_STAGES-1];
  assign sync_full = fill_q[SYNC_STAGES-1];

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      sync_q      <= '1;
      fill_q      <= '0;
      line_high_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      fill_q      <= fill_d;
      line_high_q <= sync_full & rx_sync;
    end
  end

  logic tick, baud_clear;

  uart_baud_gen u_baud_gen (
    .uart_clk   (uart_clk),
    .uart_rst_n (uart_rst_n),
    .clear      (baud_clear),
    .baud_div   (baud_div),
    .tick       (tick)
  );

  rx_state_t            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 s_a_q, s_a_d, s_b_q, s_b_d;
  logic                 armed_q, armed_d;
  logic                 perr_q, perr_d;
  logic                 start_det, bit_done, bit_val, complete, par_sum;

  assign start_det = line_high_q & sync_full & ~rx_sync;
  // armed_q is set only by a tick-A sample inside a bit window, so the partial
  // window between start validation and the first data bit never decides a bit.
  assign bit_done  = tick & (cnt_q == SampC) & armed_q;
  assign bit_val   = majority3(s_a_q, s_b_q, rx_sync);
  assign par_sum   = (^shift_q) ^ bit_val;
  assign busy      = (state_q != RxIdle);

  always_comb begin
    state_d    = state_q;
    cnt_d      = tick ? cnt_q + 1'b1 : cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    s_a_d      = s_a_q;
    s_b_d      = s_b_q;
    armed_d    = armed_q;
    perr_d     = perr_q;
    baud_clear = 1'b0;
    complete   = 1'b0;

    if (state_q == RxData || state_q == RxParity || state_q == RxStop) begin
      if (tick && cnt_q == SampA) begin
        s_a_d   = rx_sync;
        armed_d = 1'b1;
      end
      if (tick && cnt_q == SampB) begin
        s_b_d = rx_sync;
      end
      if (bit_done) begin
        armed_d = 1'b0;
      end
    end

    unique case (state_q)
      RxIdle: begin
        if (start_det) begin
          state_d    = RxStart;
          baud_clear = 1'b1;
          cnt_d      = '0;
          bit_cnt_d  = '0;
          armed_d    = 1'b0;
          perr_d     = 1'b0;
        end
      end
      RxStart: begin
        if (tick && cnt_q == SampA) begin
          if (rx_sync) begin
            state_d = RxIdle;
          end else begin
            state_d    = RxData;
            baud_clear = 1'b1;
          end
        end
      end
      RxData: begin
        if (bit_done) begin
          shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) begin
            state_d = parity_en ? RxParity : RxStop;
          end
        end
      end
      RxParity: begin
        if (bit_done) begin
          perr_d  = par_sum != (parity_odd ? ParityOdd : ParityEven);
          state_d = RxStop;
        end
      end
      RxStop: begin
        if (bit_done) begin
          complete = 1'b1;
          state_d  = bit_val ? RxIdle : RxWaitIdle;
        end
      end
      RxWaitIdle: begin
        if (rx_sync) begin
          state_d = RxIdle;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      s_a_q     <= 1'b1;
      s_b_q     <= 1'b1;
      armed_q   <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      s_a_q     <= s_a_d;
      s_b_q     <= s_b_d;
      armed_q   <= armed_d;
      perr_q    <= perr_d;
    end
  end

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    if (complete) begin
      // A same-cycle handshake frees the register, so the new frame may land.
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        rx_valid_d   = 1'b1;
        frame_err_d  = ~bit_val;
        parity_err_d = perr_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at baud_div=3 (64 clocks per bit).
module tb_uart_rx;

  localparam int BitClks = 64;

  logic        uart_clk   = 1'b0;
  logic        uart_rst_n = 1'b0;
  logic        rx         = 1'b1;
  logic [15:0] baud_div   = 16'd3;
  logic        parity_en  = 1'b0;
  logic        parity_odd = 1'b0;
  logic        rx_ready   = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, parity_err, overrun, busy;

  int n_checks = 0;
  int n_errors = 0;

  // Cumulative observations, written only by the monitor.
  int         valid_cyc = 0, hs_cnt = 0, ovr_cyc = 0, busy_cyc = 0;
  logic [7:0] last_data = '0;
  logic       last_ferr = 1'b0, last_perr = 1'b0;

  // Snapshots taken by the stimulus before each scenario.
  int v0, h0, o0, b0;

  logic [7:0] par_data [4] = '{8'h03, 8'h03, 8'h07, 8'h07};
  logic       par_odd  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       par_bit  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       par_exp  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] abort_byte;

  always #5 uart_clk = ~uart_clk;

  uart_rx #(
    .DATA_BITS   (8),
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .uart_clk   (uart_clk),
    .uart_rst_n (uart_rst_n),
    .rx         (rx),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always @(negedge uart_clk) begin
    if (rx_valid) valid_cyc++;
    if (rx_valid && rx_ready) begin
      hs_cnt++;
      last_data = rx_data;
      last_ferr = frame_err;
      last_perr = parity_err;
    end
    if (overrun) ovr_cyc++;
    if (busy) busy_cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    v0 = valid_cyc;
    h0 = hs_cnt;
    o0 = ovr_cyc;
    b0 = busy_cyc;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge uart_clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_clks(BitClks);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par,
                            input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(par);
    drive_bit(stop);
  endtask

  // Ready changes just after the rising edge so the monitor sees the same value the DUT uses.
  task automatic set_ready(input logic v);
    @(posedge uart_clk);
    #1 rx_ready = v;
  endtask

  initial begin
    wait_clks(4);
    check_eq("rst_data", rx_data, 8'h00);
    check_eq("rst_valid", rx_valid, 1'b0);
    check_eq("rst_ferr", frame_err, 1'b0);
    check_eq("rst_perr", parity_err, 1'b0);
    check_eq("rst_ovr", overrun, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    uart_rst_n = 1'b1;
    wait_clks(10);

    // 8N1 0xA5, consumer always ready
    mark();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_clks(BitClks);
    check_eq("a5_handshakes", hs_cnt - h0, 1);
    check_eq("a5_data", last_data, 8'hA5);
    check_eq("a5_valid_cycles", valid_cyc - v0, 1);
    check_eq("a5_ferr", last_ferr, 1'b0);
    check_eq("a5_perr", last_perr, 1'b0);
    check_eq("a5_overrun", ovr_cyc - o0, 0);
    check_eq("a5_busy_after", busy, 1'b0);

    // Parity frames: even/odd, correct and wrong parity bits
    for (int i = 0; i < 4; i++) begin
      parity_en  = 1'b1;
      parity_odd = par_odd[i];
      mark();
      send_frame(par_data[i], 1'b1, par_bit[i], 1'b1);
      wait_clks(BitClks);
      check_eq($sformatf("par%0d_handshakes", i), hs_cnt - h0, 1);
      check_eq($sformatf("par%0d_data", i), last_data, par_data[i]);
      check_eq($sformatf("par%0d_perr", i), last_perr, par_exp[i]);
    end
    parity_en  = 1'b0;
    parity_odd = 1'b0;

    // Stop bit 0 then line held low: one framing-error frame, then stuck in wait
    mark();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    wait_clks(3 * BitClks);
    check_eq("brk_busy_low", busy, 1'b1);
    check_eq("brk_one_frame", hs_cnt - h0, 1);
    check_eq("brk_data", last_data, 8'h55);
    check_eq("brk_ferr", last_ferr, 1'b1);
    check_eq("brk_perr", last_perr, 1'b0);
    rx = 1'b1;
    wait_clks(2 * BitClks);
    check_eq("brk_busy_released", busy, 1'b0);
    check_eq("brk_no_second", hs_cnt - h0, 1);

    // Overrun: two frames while not ready
    set_ready(1'b0);
    mark();
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    wait_clks(BitClks);
    check_eq("ovr_valid_held", rx_valid, 1'b1);
    check_eq("ovr_data_kept", rx_data, 8'h11);
    check_eq("ovr_pulse_cycles", ovr_cyc - o0, 1);
    check_eq("ovr_no_handshake", hs_cnt - h0, 0);
    check_eq("ovr_ferr", frame_err, 1'b0);
    set_ready(1'b1);
    wait_clks(2);
    check_eq("ovr_valid_cleared", rx_valid, 1'b0);
    check_eq("ovr_one_handshake", hs_cnt - h0, 1);
    check_eq("ovr_handshake_data", last_data, 8'h11);

    // 20-clock low glitch: false start
    mark();
    rx = 1'b0;
    wait_clks(20);
    rx = 1'b1;
    wait_clks(2 * BitClks);
    check_eq("glitch_busy_rose", (busy_cyc - b0) > 0, 1'b1);
    check_eq("glitch_busy_fell", busy, 1'b0);
    check_eq("glitch_no_valid", valid_cyc - v0, 0);

    // Reset during data bit 4 of 0x7E
    mark();
    abort_byte = 8'h7E;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(abort_byte[i]);
    rx = abort_byte[4];
    wait_clks(BitClks / 2);
    uart_rst_n = 1'b0;
    wait_clks(3);
    check_eq("rstmid_data", rx_data, 8'h00);
    check_eq("rstmid_valid", rx_valid, 1'b0);
    check_eq("rstmid_busy", busy, 1'b0);
    check_eq("rstmid_flags", {frame_err, parity_err, overrun}, 3'b000);
    uart_rst_n = 1'b1;
    rx = 1'b1;
    wait_clks(2 * BitClks);
    check_eq("rstmid_no_valid", valid_cyc - v0, 0);
    mark();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_clks(BitClks);
    check_eq("post_rst_handshakes", hs_cnt - h0, 1);
    check_eq("post_rst_data", last_data, 8'h3C);
    check_eq("post_rst_ferr", last_ferr, 1'b0);

    // Reset released with the line low must not start a frame
    rx = 1'b0;
    wait_clks(2);
    uart_rst_n = 1'b0;
    wait_clks(3);
    mark();
    uart_rst_n = 1'b1;
    wait_clks(3 * BitClks);
    check_eq("lowrel_no_busy", busy_cyc - b0, 0);
    check_eq("lowrel_no_valid", valid_cyc - v0, 0);
    rx = 1'b1;
    wait_clks(BitClks);
    mark();
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    wait_clks(BitClks);
    check_eq("lowrel_next_data", last_data, 8'hC3);
    check_eq("lowrel_next_handshakes", hs_cnt - h0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
